spike_aer_encoder: RTL and testbench

- Transmit side of the 12-bit spike word interface consumed by neuron on spikei.
- Collects spike requests from a bank of NUM_NEURONS neurons and serializes them, one per cycle, into words {type[1:0], address[9:0]}.
- Arbitration is round-robin. Words are buffered in a small FIFO and handed downstream with a valid/ready handshake.
- Sits between the neuron array outputs and the spike broadcast fabric.

---
 rtl/spike_aer_encoder_pkg.sv | 18 +
 rtl/spike_aer_encoder_if.sv | 13 +
 rtl/spike_aer_encoder_fifo.sv | 55 +++++
 rtl/spike_aer_encoder.sv | 112 +++++++++++
 tb/tb_spike_aer_encoder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/spike_aer_encoder_pkg.sv
// Shared definitions for the AER spike word: type codes, field widths and the word packer.
package spike_pkg;

    localparam int SPK_ADDR_W = 10;
    localparam int SPK_WORD_W = SPK_ADDR_W + 2;

    typedef enum logic [1:0] {
        SPK_TYPE_NONE = 2'b00,
        SPK_TYPE_POS  = 2'b01,
        SPK_TYPE_NEG  = 2'b10
    } spk_type_e;

    function automatic logic [SPK_WORD_W-1:0] spk_pack(input spk_type_e  t,
                                                       input logic [SPK_ADDR_W-1:0] a);
        return {t, a};
    endfunction

endpackage

// File: rtl/spike_aer_encoder_if.sv
// Valid/ready spike word channel from the encoder to the broadcast fabric.
interface spike_aer_if
    import spike_pkg::*;
#(
    parameter int WORD_W = SPK_WORD_W
);
    logic [WORD_W-1:0] spikeo;
    logic              spikeo_valid;
    logic              spikeo_ready;

    modport master (output spikeo, output spikeo_valid, input  spikeo_ready);
    modport slave  (input  spikeo, input  spikeo_valid, output spikeo_ready);
endinterface

// File: rtl/spike_aer_encoder_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module spike_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: the storage array is deliberately not reset; the pointers and count alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    // NOTE: sequential state uses non-blocking '<=' so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Captures per-neuron spike pulses, arbitrates them round-robin and queues AER words downstream.
module spike_aer_encoder
    import spike_pkg::*;
#(
    parameter int          NUM_NEURONS = 16,
    parameter int          ADDR_W      = SPK_ADDR_W,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [NUM_NEURONS-1:0]      spike_req,
    input  logic [NUM_NEURONS-1:0]      spike_sign,
    spike_aer_if.master                 aer,
    output logic                        pending_any,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [15:0]                 drop_cnt
);
    localparam int IDX_W  = $clog2(NUM_NEURONS);
    localparam int WORD_W = ADDR_W + 2;

    logic [NUM_NEURONS-1:0] r_pending;
    logic [NUM_NEURONS-1:0] r_sign;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [15:0]            r_drop_cnt;

    logic                   w_found;
    logic                   w_grant;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [IDX_W-1:0]       w_grant_idx;
    logic [NUM_NEURONS-1:0] w_grant_mask;
    logic [NUM_NEURONS-1:0] w_set;
    logic [NUM_NEURONS-1:0] w_merge;
    logic [NUM_NEURONS-1:0] w_load;
    logic [6:0]             w_merge_cnt;
    logic [16:0]            w_drop_sum;
    spk_type_e              w_type;
    logic [ADDR_W-1:0]      w_addr;
    logic [WORD_W-1:0]      w_push_word;
    logic [WORD_W-1:0]      w_head;

    // NOTE: combinational logic uses blocking '=' and assigns every output first, so no latch is inferred.
    always_comb begin : arbiter
        int j;
        w_found     = 1'b0;
        w_grant_idx = '0;
        j           = 0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NUM_NEURONS) j = j - NUM_NEURONS;
            if (!w_found && r_pending[j]) begin
                w_found     = 1'b1;
                w_grant_idx = IDX_W'(j);
            end
        end
    end

    assign w_pop        = !w_empty && aer.spikeo_ready;
    assign w_grant      = w_found && (!w_full || w_pop);
    assign w_grant_mask = w_grant ? (NUM_NEURONS'(1) << w_grant_idx) : '0;

    // A request on a bit still pending after this cycle's grant is merged; all others load a fresh sign.
    assign w_set       = en ? spike_req : '0;
    assign w_merge     = w_set & r_pending & ~w_grant_mask;
    assign w_load      = w_set & ~w_merge;
    assign w_merge_cnt = 7'($countones(w_merge));
    assign w_drop_sum  = {1'b0, r_drop_cnt} + {10'd0, w_merge_cnt};

    assign w_type      = r_sign[w_grant_idx] ? SPK_TYPE_NEG : SPK_TYPE_POS;
    assign w_addr      = ADDR_W'(BASE_ADDR) + ADDR_W'(w_grant_idx);
    assign w_push_word = spk_pack(w_type, w_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending  <= '0;
            r_sign     <= '0;
            r_rr_ptr   <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_pending  <= (r_pending & ~w_grant_mask) | w_set;
            r_sign     <= (r_sign & ~w_load) | (spike_sign & w_load);
            if (w_grant) begin
                r_rr_ptr <= (int'(w_grant_idx) == NUM_NEURONS - 1) ? '0 : w_grant_idx + IDX_W'(1);
            end
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    spike_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_grant),
        .i_data  (w_push_word),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign aer.spikeo_valid = !w_empty;
    assign aer.spikeo       = w_empty ? '0 : w_head;
    assign pending_any      = |r_pending;
    assign drop_cnt         = r_drop_cnt;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Random and directed stimulus on two encoders (base 0 and base 0x3FE) against a queue-based model.
module tb_spike_aer_encoder;

    localparam int N      = 16;
    localparam int DEPTH  = 8;
    localparam int BASE_B = 'h3FE;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [N-1:0]  spike_req;
    logic [N-1:0]  spike_sign;
    logic          ready;
    logic          pend_a, pend_b;
    logic [3:0]    cnt_a, cnt_b;
    logic [15:0]   drop_a, drop_b;

    spike_aer_if #(.WORD_W(12)) aer_a ();
    spike_aer_if #(.WORD_W(12)) aer_b ();

    assign aer_a.spikeo_ready = ready;
    assign aer_b.spikeo_ready = ready;

    spike_aer_encoder #(.NUM_NEURONS(N), .ADDR_W(10), .BASE_ADDR(0), .FIFO_DEPTH(DEPTH)) u_dut_a (
        .clk(clk), .reset(reset), .en(en), .spike_req(spike_req), .spike_sign(spike_sign),
        .aer(aer_a), .pending_any(pend_a), .fifo_count(cnt_a), .drop_cnt(drop_a)
    );

    spike_aer_encoder #(.NUM_NEURONS(N), .ADDR_W(10), .BASE_ADDR(BASE_B), .FIFO_DEPTH(DEPTH)) u_dut_b (
        .clk(clk), .reset(reset), .en(en), .spike_req(spike_req), .spike_sign(spike_sign),
        .aer(aer_b), .pending_any(pend_b), .fifo_count(cnt_b), .drop_cnt(drop_b)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: which neurons wait, their sign, the queued (neuron, sign) pairs, RR start, drops.
    bit m_pend [N];
    bit m_sign [N];
    int q_idx  [$];
    bit q_neg  [$];
    int m_rr;
    int m_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_word(input int base, input int idx, input bit neg);
        return 12'((neg ? 2048 : 1024) + ((base + idx) % 1024));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_sign[i] = 1'b0;
        end
        q_idx.delete();
        q_neg.delete();
        m_rr   = 0;
        m_drop = 0;
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] sgn, input bit e, input bit r);
        int g;
        bit pop;
        g   = -1;
        pop = (q_idx.size() > 0) && r;
        if (q_idx.size() < DEPTH || pop) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        if (pop) begin
            void'(q_idx.pop_front());
            void'(q_neg.pop_front());
        end
        if (g >= 0) begin
            q_idx.push_back(g);
            q_neg.push_back(m_sign[g]);
            m_pend[g] = 1'b0;
            m_rr      = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
            if (e && req[i]) begin
                if (m_pend[i]) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    m_pend[i] = 1'b1;
                    m_sign[i] = sgn[i];
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit any;
        logic [11:0] exp_a, exp_b;
        any   = 1'b0;
        exp_a = '0;
        exp_b = '0;
        for (int i = 0; i < N; i++) any |= m_pend[i];
        if (q_idx.size() > 0) begin
            exp_a = ref_word(0, q_idx[0], q_neg[0]);
            exp_b = ref_word(BASE_B, q_idx[0], q_neg[0]);
        end
        check("valid_a", 32'(aer_a.spikeo_valid), 32'(q_idx.size() > 0));
        check("valid_b", 32'(aer_b.spikeo_valid), 32'(q_idx.size() > 0));
        check("word_a",  32'(aer_a.spikeo), 32'(exp_a));
        check("word_b",  32'(aer_b.spikeo), 32'(exp_b));
        check("count_a", 32'(cnt_a), 32'(q_idx.size()));
        check("count_b", 32'(cnt_b), 32'(q_idx.size()));
        check("pend_a",  32'(pend_a), 32'(any));
        check("pend_b",  32'(pend_b), 32'(any));
        check("drop_a",  32'(drop_a), 32'(m_drop));
        check("drop_b",  32'(drop_b), 32'(m_drop));
    endtask

    task automatic drive_step(input logic [N-1:0] req, input logic [N-1:0] sgn, input bit e, input bit r);
        spike_req  = req;
        spike_sign = sgn;
        en         = e;
        ready      = r;
        @(posedge clk);
        model_step(req, sgn, e, r);
        #1;
        check_outputs();
    endtask

    task automatic idle(input bit r);
        drive_step('0, '0, 1'b1, r);
    endtask

    // Asserts reset between edges and expects every output to clear before the next edge.
    task automatic apply_reset();
        reset     = 1'b1;
        spike_req = '0;
        en        = 1'b0;
        ready     = 1'b0;
        model_reset();
        #1;
        check("rst_valid", 32'(aer_a.spikeo_valid), 0);
        check("rst_word",  32'(aer_a.spikeo), 0);
        check("rst_count", 32'(cnt_a), 0);
        check("rst_pend",  32'(pend_a), 0);
        check("rst_drop",  32'(drop_a), 0);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [N-1:0] req;
        reset = 1'b1; en = 1'b0; spike_req = '0; spike_sign = '0; ready = 1'b0;
        apply_reset();

        // Single positive request from neuron 6: one word after the second edge, then nothing.
        drive_step(16'h0040, 16'h0000, 1'b1, 1'b1);
        check("single_early", 32'(aer_a.spikeo_valid), 0);
        idle(1'b1);
        check("single_word", 32'(aer_a.spikeo), 32'h406);
        idle(1'b1);
        check("single_gone", 32'(aer_a.spikeo), 0);

        // Round-robin from pointer 0, then from pointer 1.
        apply_reset();
        drive_step(16'h8011, 16'h0000, 1'b1, 1'b1);
        idle(1'b1); check("rr_0",  32'(aer_a.spikeo), 32'h400);
        idle(1'b1); check("rr_4",  32'(aer_a.spikeo), 32'h404);
        idle(1'b1); check("rr_15", 32'(aer_a.spikeo), 32'h40F);
        drive_step(16'h0001, 16'h0000, 1'b1, 1'b1);
        repeat (3) idle(1'b1);
        drive_step(16'h0011, 16'h0000, 1'b1, 1'b1);
        idle(1'b1); check("rr1_4", 32'(aer_a.spikeo), 32'h404);
        idle(1'b1); check("rr1_0", 32'(aer_a.spikeo), 32'h400);
        idle(1'b1);

        // Backpressure: 12 requests, only 8 fit, the rest stay pending until drained.
        apply_reset();
        drive_step(16'h0FFF, 16'($urandom), 1'b1, 1'b0);
        repeat (12) idle(1'b0);
        check("bp_full", 32'(cnt_a), 8);
        check("bp_pend", 32'(pend_a), 1);
        repeat (14) idle(1'b1);
        check("bp_drained", 32'(cnt_a), 0);
        check("bp_no_drop", 32'(drop_a), 0);

        // Merge on neuron 3 while the FIFO is full keeps the first (positive) sign.
        apply_reset();
        drive_step(16'hFF00, 16'h0000, 1'b1, 1'b0);
        repeat (9) idle(1'b0);
        drive_step(16'h0008, 16'h0000, 1'b1, 1'b0);
        drive_step(16'h0008, 16'h0008, 1'b1, 1'b0);
        check("merge_drop", 32'(drop_a), 1);
        repeat (12) idle(1'b1);
        check("merge_empty", 32'(cnt_a), 0);

        // Saturation: every neuron requests every cycle with the FIFO stalled.
        apply_reset();
        repeat (4500) drive_step(16'hFFFF, 16'($urandom), 1'b1, 1'b0);
        check("drop_sat", 32'(drop_a), 32'hFFFF);

        // Negative spike from neuron 5: base 0x3FE wraps to address 3.
        apply_reset();
        drive_step(16'h0020, 16'h0020, 1'b1, 1'b1);
        idle(1'b1);
        check("neg_wrap_b",  32'(aer_b.spikeo), 32'h803);
        check("neg_local_a", 32'(aer_a.spikeo), 32'h805);
        idle(1'b1);

        // Reset mid-operation with five words queued.
        drive_step(16'h001F, 16'($urandom), 1'b1, 1'b0);
        repeat (6) idle(1'b0);
        check("queued5", 32'(cnt_a), 5);
        apply_reset();

        // Capture disabled: requests are ignored.
        repeat (10) drive_step(16'($urandom), 16'($urandom), 1'b0, 1'b1);
        check("en0_count", 32'(cnt_a), 0);
        check("en0_pend",  32'(pend_a), 0);

        // Random traffic with random enable and backpressure.
        repeat (3000) begin
            req = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'($urandom)) : '0;
            drive_step(req, 16'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
        end
        repeat (40) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
